// File: rtl/clk_divider_multi_if.sv
// Configuration and output bundle for the multi-channel clock divider.
// The master side programs divisors and run/sync controls; the slave side
// (the divider) returns the divided clocks, ticks and pending flags.
interface clk_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 28
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [WIDTH-1:0]    cfg_div;
  logic [CHANNELS-1:0] ch_run;
  logic                sync;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;

  modport master (
    output cfg_we, cfg_ch, cfg_div, ch_run, sync,
    input  clk_out, tick, pending
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, ch_run, sync,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider / clock-enable generator.
// Each channel counts 0..div_act-1 and emits a registered ~50% duty clock
// (low floor(div/2) cycles, high ceil(div/2) cycles) plus a one-cycle tick
// in cycle 0 of each new period. New divisors land in a shadow register and
// only become active at a period boundary, on sync, or while stopped, so a
// running period is never cut short or stretched.
module clk_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  clk_divider_multi_if.slave   bus
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]    cfg_div_clamped;
  logic [CHANNELS-1:0] clk_out_vec;
  logic [CHANNELS-1:0] tick_vec;
  logic [CHANNELS-1:0] pending_vec;

  // A zero divisor would make the wrap compare underflow, so it is stored as 1.
  assign cfg_div_clamped = (bus.cfg_div == '0) ? ONE : bus.cfg_div;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_reg, cnt_next;
      logic [WIDTH-1:0] div_act_reg, div_act_next;
      logic [WIDTH-1:0] div_sh_reg, div_sh_next;
      logic             clk_out_reg, tick_reg;
      logic             wrap, wr_hit, load;

      // Next-state: shadow write, active-divisor load with same-cycle bypass, counter.
      always_comb begin
        wr_hit       = bus.cfg_we && (int'(bus.cfg_ch) == gi);
        wrap         = bus.ch_run[gi] && (cnt_reg == div_act_reg - ONE);
        div_sh_next  = wr_hit ? cfg_div_clamped : div_sh_reg;
        load         = wrap || bus.sync || !bus.ch_run[gi];
        div_act_next = load ? div_sh_next : div_act_reg;
        if (!bus.ch_run[gi] || bus.sync || wrap) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end

      // State and registered outputs; clk_out is derived from post-edge values.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg     <= '0;
          div_act_reg <= DIV_RST;
          div_sh_reg  <= DIV_RST;
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          div_act_reg <= div_act_next;
          div_sh_reg  <= div_sh_next;
          clk_out_reg <= bus.ch_run[gi] && (cnt_next >= (div_act_next >> 1));
          tick_reg    <= wrap && !bus.sync;
        end
      end

      assign clk_out_vec[gi] = clk_out_reg;
      assign tick_vec[gi]    = tick_reg;
      assign pending_vec[gi] = (div_sh_reg != div_act_reg);
    end
  endgenerate

  assign bus.clk_out = clk_out_vec;
  assign bus.tick    = tick_vec;
  assign bus.pending = pending_vec;

endmodule
